lpm_elastic_dffpipe: RTL and testbench

// - Parametrised delay pipeline with per-stage valid bits and valid/ready flow control.
// - Successor to the fixed-latency dual-clock FIFO delay pipe: adds stall, bubble collapse,

---
 rtl/lpm_elastic_dffpipe_pkg.sv | 26 ++
 rtl/lpm_elastic_dffpipe_if.sv | 25 ++
 rtl/lpm_elastic_dffpipe_stage.sv | 30 +++
 rtl/lpm_elastic_dffpipe.sv | 106 ++++++++++
 tb/tb_lpm_elastic_dffpipe.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/lpm_elastic_dffpipe_pkg.sv
// Shared constants and width helpers for the elastic delay pipe.
package lpm_pipe_pkg;

    localparam bit LPM_COLLAPSE_ON  = 1'b1;
    localparam bit LPM_COLLAPSE_OFF = 1'b0;

    // Ceiling log2; 0 and 1 both map to 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = int'(i + 1);
            end
        end
        return result;
    endfunction

    // Occupancy counter width: enough bits to hold 0..delay, never narrower than 1.
    function automatic int unsigned occ_width(input int unsigned delay);
        int unsigned bits;
        bits = clog2(delay + 1);
        return (bits > 1) ? bits : 1;
    endfunction

endpackage

// File: rtl/lpm_elastic_dffpipe_if.sv
// Valid/ready bus of the elastic delay pipe: upstream, downstream and occupancy.
interface lpm_elastic_dffpipe_if #(
    parameter int unsigned width     = 64,
    parameter int unsigned cnt_width = 1
);
    logic                 in_valid;
    logic                 in_ready;
    logic [width-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [width-1:0]     out_data;
    logic [cnt_width-1:0] occupancy;

    // Producer/consumer side that drives the pipe.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    // The pipe itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/lpm_elastic_dffpipe_stage.sv
// One register slice of the elastic pipe: a valid bit plus a data word.
module lpm_elastic_stage #(
    parameter int unsigned lpm_width = 64
) (
    input  logic                 clock,
    input  logic                 aclr,
    input  logic                 sclr,
    input  logic                 load,
    input  logic                 vin,
    input  logic [lpm_width-1:0] din,
    output logic                 vout,
    output logic [lpm_width-1:0] dout
);

    // Flush clears only the valid bit; data is captured only alongside a valid word.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            vout <= 1'b0;
            dout <= '0;
        end else if (sclr) begin
            vout <= 1'b0;
        end else if (load) begin
            vout <= vin;
            if (vin) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/lpm_elastic_dffpipe.sv
// Elastic delay pipeline: lpm_delay register stages with valid/ready flow control,
// optional bubble collapse, synchronous flush and a registered occupancy count.
module lpm_elastic_dffpipe
    import lpm_pipe_pkg::*;
#(
    parameter int unsigned lpm_width    = 64,
    parameter int unsigned lpm_delay    = 1,
    parameter bit          lpm_collapse = LPM_COLLAPSE_ON
) (
    input  logic                    clock,
    input  logic                    aclr,
    input  logic                    sclr,
    lpm_elastic_dffpipe_if.slave    bus
);

    localparam int unsigned occ_bits = occ_width(lpm_delay);

    if (lpm_delay == 0) begin : g_bypass
        assign bus.out_valid = bus.in_valid;
        assign bus.out_data  = bus.in_data;
        assign bus.in_ready  = bus.out_ready & ~sclr & ~aclr;
        assign bus.occupancy = '0;
    end else begin : g_pipe
        typedef logic [occ_bits-1:0] occ_t;

        logic [lpm_delay-1:0] v;
        logic [lpm_delay-1:0] vin;
        logic [lpm_delay-1:0] v_next;
        logic [lpm_delay-1:0] load;
        logic [lpm_width-1:0] d   [lpm_delay];
        logic [lpm_width-1:0] din [lpm_delay];
        logic                 in_rdy_raw;
        logic                 in_ready;
        occ_t                 occ_q;
        occ_t                 occ_d;

        if (lpm_collapse == LPM_COLLAPSE_ON) begin : g_collapse
            // Walk back from the output: a stage takes data if it is empty or its successor can.
            always_comb begin
                logic r;
                load = '0;
                r    = bus.out_ready;
                for (int k = int'(lpm_delay) - 1; k >= 0; k--) begin
                    r       = r | ~v[k];
                    load[k] = r;
                end
            end
            assign in_rdy_raw = load[0];
        end else begin : g_global
            logic en;
            assign en         = bus.out_ready | ~v[lpm_delay-1];
            assign load       = {lpm_delay{en}};
            assign in_rdy_raw = en;
        end

        assign in_ready = in_rdy_raw & ~sclr & ~aclr;

        for (genvar k = 0; k < lpm_delay; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign vin[k] = bus.in_valid & in_ready;
                assign din[k] = bus.in_data;
            end else begin : g_body
                assign vin[k] = v[k-1];
                assign din[k] = d[k-1];
            end

            lpm_elastic_stage #(
                .lpm_width (lpm_width)
            ) u_stage (
                .clock (clock),
                .aclr  (aclr),
                .sclr  (sclr),
                .load  (load[k]),
                .vin   (vin[k]),
                .din   (din[k]),
                .vout  (v[k]),
                .dout  (d[k])
            );
        end

        // Mirror the stage update so the count changes on the same edge as the valids.
        always_comb begin
            v_next = '0;
            occ_d  = '0;
            for (int k = 0; k < int'(lpm_delay); k++) begin
                v_next[k] = sclr ? 1'b0 : (load[k] ? vin[k] : v[k]);
                occ_d     = occ_d + occ_t'(v_next[k]);
            end
        end

        // Registered occupancy, cleared with the stages.
        always_ff @(posedge clock or posedge aclr) begin
            if (aclr) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end

        assign bus.in_ready  = in_ready;
        assign bus.out_valid = v[lpm_delay-1];
        assign bus.out_data  = d[lpm_delay-1];
        assign bus.occupancy = occ_q;
    end

endmodule

// File: tb/tb_lpm_elastic_dffpipe.sv
// Directed bench: L=3 collapsing and global-enable pipes side by side, plus an L=0 bypass.
module tb_lpm_elastic_dffpipe;

    logic clock = 1'b0;
    logic aclr;
    logic sclr;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clock = ~clock;

    lpm_elastic_dffpipe_if #(.width(8), .cnt_width(2)) bc ();
    lpm_elastic_dffpipe_if #(.width(8), .cnt_width(2)) bg ();
    lpm_elastic_dffpipe_if #(.width(8), .cnt_width(1)) bz ();

    lpm_elastic_dffpipe #(.lpm_width(8), .lpm_delay(3), .lpm_collapse(1'b1)) u_col (
        .clock (clock),
        .aclr  (aclr),
        .sclr  (sclr),
        .bus   (bc)
    );

    lpm_elastic_dffpipe #(.lpm_width(8), .lpm_delay(3), .lpm_collapse(1'b0)) u_glb (
        .clock (clock),
        .aclr  (aclr),
        .sclr  (sclr),
        .bus   (bg)
    );

    lpm_elastic_dffpipe #(.lpm_width(8), .lpm_delay(0), .lpm_collapse(1'b1)) u_byp (
        .clock (clock),
        .aclr  (aclr),
        .sclr  (sclr),
        .bus   (bz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic next_window;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic drive_l3(input logic iv, input logic [7:0] data, input logic ordy);
        bc.in_valid  = iv;
        bc.in_data   = data;
        bc.out_ready = ordy;
        bg.in_valid  = iv;
        bg.in_data   = data;
        bg.out_ready = ordy;
    endtask

    task automatic check_pipe(input string tag, input bit gbl, input int exp_occ,
                              input logic exp_ov, input logic [7:0] exp_od, input logic exp_ir);
        string who;
        who = gbl ? "glb" : "col";
        chk($sformatf("%s_%s_occ", tag, who),
            gbl ? 32'(bg.occupancy) : 32'(bc.occupancy), 32'(exp_occ));
        chk($sformatf("%s_%s_ov", tag, who),
            gbl ? 32'(bg.out_valid) : 32'(bc.out_valid), 32'(exp_ov));
        chk($sformatf("%s_%s_ir", tag, who),
            gbl ? 32'(bg.in_ready) : 32'(bc.in_ready), 32'(exp_ir));
        if (exp_ov) begin
            chk($sformatf("%s_%s_od", tag, who),
                gbl ? 32'(bg.out_data) : 32'(bc.out_data), 32'(exp_od));
        end
    endtask

    task automatic step(input string tag, input logic iv, input logic [7:0] data,
                        input logic ordy, input logic s,
                        input int c_occ, input logic c_ov, input logic [7:0] c_od,
                        input logic c_ir,
                        input int g_occ, input logic g_ov, input logic [7:0] g_od,
                        input logic g_ir);
        next_window;
        drive_l3(iv, data, ordy);
        sclr = s;
        settle;
        check_pipe(tag, 1'b0, c_occ, c_ov, c_od, c_ir);
        check_pipe(tag, 1'b1, g_occ, g_ov, g_od, g_ir);
    endtask

    initial begin
        int exp_occ;

        // Reset held with traffic offered.
        aclr = 1'b1;
        sclr = 1'b0;
        drive_l3(1'b1, 8'h55, 1'b1);
        bz.in_valid  = 1'b1;
        bz.in_data   = 8'h55;
        bz.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_window;
            settle;
            check_pipe("reset", 1'b0, 0, 1'b0, 8'h00, 1'b0);
            check_pipe("reset", 1'b1, 0, 1'b0, 8'h00, 1'b0);
            chk("reset_col_od", 32'(bc.out_data), 32'h0);
            chk("reset_glb_od", 32'(bg.out_data), 32'h0);
            chk("reset_byp_ir", 32'(bz.in_ready), 32'h0);
        end
        next_window;
        aclr = 1'b0;
        drive_l3(1'b0, 8'h55, 1'b1);
        bz.in_valid = 1'b0;
        settle;
        check_pipe("release", 1'b0, 0, 1'b0, 8'h00, 1'b1);
        check_pipe("release", 1'b1, 0, 1'b0, 8'h00, 1'b1);
        chk("release_byp_ir", 32'(bz.in_ready), 32'h1);
        for (int i = 0; i < 2; i++) begin
            next_window;
            settle;
            check_pipe("idle", 1'b0, 0, 1'b0, 8'h00, 1'b1);
            check_pipe("idle", 1'b1, 0, 1'b0, 8'h00, 1'b1);
        end

        // Back-to-back stream 1..8: first word at window 3, three stages full in steady state.
        for (int c = 0; c < 12; c++) begin
            next_window;
            drive_l3(c < 8, 8'(c + 1), 1'b1);
            settle;
            exp_occ = (c <= 8) ? ((c < 3) ? c : 3) : 11 - c;
            check_pipe($sformatf("stream%0d", c), 1'b0, exp_occ, c >= 3 && c <= 10,
                       8'(c - 2), 1'b1);
            check_pipe($sformatf("stream%0d", c), 1'b1, exp_occ, c >= 3 && c <= 10,
                       8'(c - 2), 1'b1);
        end

        // A, gap, B then stall: collapse squeezes the bubble, global enable keeps it.
        step("stall0", 1'b1, 8'hA1, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1);
        step("stall1", 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 8'h00, 1'b1, 1, 1'b0, 8'h00, 1'b1);
        step("stall2", 1'b1, 8'hB2, 1'b1, 1'b0, 1, 1'b0, 8'h00, 1'b1, 1, 1'b0, 8'h00, 1'b1);
        step("stall3", 1'b1, 8'hC3, 1'b0, 1'b0, 2, 1'b1, 8'hA1, 1'b1, 2, 1'b1, 8'hA1, 1'b0);
        step("stall4", 1'b1, 8'hD4, 1'b0, 1'b0, 3, 1'b1, 8'hA1, 1'b0, 2, 1'b1, 8'hA1, 1'b0);
        step("stall5", 1'b1, 8'hD4, 1'b0, 1'b0, 3, 1'b1, 8'hA1, 1'b0, 2, 1'b1, 8'hA1, 1'b0);
        step("stall6", 1'b1, 8'hD4, 1'b1, 1'b0, 3, 1'b1, 8'hA1, 1'b1, 2, 1'b1, 8'hA1, 1'b1);
        step("stall7", 1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 8'hB2, 1'b1, 2, 1'b0, 8'h00, 1'b1);
        step("stall8", 1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'hC3, 1'b1, 2, 1'b1, 8'hB2, 1'b1);
        step("stall9", 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'hD4, 1'b1, 1, 1'b1, 8'hD4, 1'b1);
        step("stall10", 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1);

        // Flush with three words in flight: head delivered, rest dropped, data regs kept.
        step("flush0", 1'b1, 8'h11, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1);
        step("flush1", 1'b1, 8'h22, 1'b1, 1'b0, 1, 1'b0, 8'h00, 1'b1, 1, 1'b0, 8'h00, 1'b1);
        step("flush2", 1'b1, 8'h33, 1'b1, 1'b0, 2, 1'b0, 8'h00, 1'b1, 2, 1'b0, 8'h00, 1'b1);
        step("flush3", 1'b1, 8'h44, 1'b1, 1'b1, 3, 1'b1, 8'h11, 1'b0, 3, 1'b1, 8'h11, 1'b0);
        step("flush4", 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1);
        chk("flush_col_keep_od", 32'(bc.out_data), 32'h11);
        chk("flush_glb_keep_od", 32'(bg.out_data), 32'h11);
        step("flush5", 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset with two words in flight: nothing partial comes out afterwards.
        step("mid0", 1'b1, 8'h61, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1);
        step("mid1", 1'b1, 8'h62, 1'b1, 1'b0, 1, 1'b0, 8'h00, 1'b1, 1, 1'b0, 8'h00, 1'b1);
        next_window;
        drive_l3(1'b0, 8'h00, 1'b1);
        aclr = 1'b1;
        settle;
        check_pipe("mid_rst", 1'b0, 0, 1'b0, 8'h00, 1'b0);
        check_pipe("mid_rst", 1'b1, 0, 1'b0, 8'h00, 1'b0);
        chk("mid_rst_col_od", 32'(bc.out_data), 32'h0);
        chk("mid_rst_glb_od", 32'(bg.out_data), 32'h0);
        next_window;
        aclr = 1'b0;
        settle;
        check_pipe("mid_rel", 1'b0, 0, 1'b0, 8'h00, 1'b1);
        check_pipe("mid_rel", 1'b1, 0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            next_window;
            settle;
            check_pipe("mid_idle", 1'b0, 0, 1'b0, 8'h00, 1'b1);
            check_pipe("mid_idle", 1'b1, 0, 1'b0, 8'h00, 1'b1);
        end

        // Zero-delay bypass: combinational data path, ready follows downstream.
        bz.in_valid  = 1'b1;
        bz.in_data   = 8'hA5;
        bz.out_ready = 1'b1;
        settle;
        chk("byp_od", 32'(bz.out_data), 32'hA5);
        chk("byp_ov", 32'(bz.out_valid), 32'h1);
        chk("byp_ir_hi", 32'(bz.in_ready), 32'h1);
        chk("byp_occ", 32'(bz.occupancy), 32'h0);
        bz.out_ready = 1'b0;
        settle;
        chk("byp_ir_lo", 32'(bz.in_ready), 32'h0);
        chk("byp_od_stall", 32'(bz.out_data), 32'hA5);
        bz.out_ready = 1'b1;
        settle;
        chk("byp_ir_again", 32'(bz.in_ready), 32'h1);
        sclr = 1'b1;
        settle;
        chk("byp_ir_sclr", 32'(bz.in_ready), 32'h0);
        sclr = 1'b0;
        bz.in_valid = 1'b0;
        settle;
        chk("byp_ir_after", 32'(bz.in_ready), 32'h1);
        chk("byp_ov_lo", 32'(bz.out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
